// File: rtl/cc_miss_request_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cc_miss_request_unit                                            |
// | Desc     : Miss-path AR issue stage; pushes miss word address at AR accept |
// |            and tracks outstanding line fills to gate R-channel ready.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cc_miss_request_unit #(
   parameter logic [3:0] ARID            = 4'd0,
   parameter int         MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_req_valid_i,
   input  logic [31:0] miss_req_addr_i,
   output logic        miss_req_ready_o,
   output logic        mem_arvalid_o,
   input  logic        mem_arready_i,
   output logic [31:0] mem_araddr_o,
   output logic [3:0]  mem_arlen_o,
   output logic [2:0]  mem_arsize_o,
   output logic [1:0]  mem_arburst_o,
   output logic [3:0]  mem_arid_o,
   input  logic        mem_rvalid_i,
   input  logic        mem_rlast_i,
   output logic        mem_rready_o,
   input  logic        miss_addr_fifo_full_i,
   output logic        miss_addr_fifo_wren_o,
   output logic [28:0] miss_addr_fifo_wdata_o
);

   localparam int              CNT_W     = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [28:0]        r_addr_q;
   logic [CNT_W-1:0]   r_out_cnt;
   logic               w_accept;
   logic               w_ar_hs;
   logic               w_r_done;

   // Burst shape is fixed: 8 x 8-byte beats, WRAP, critical word first.
   assign mem_arlen_o   = 4'd7;
   assign mem_arsize_o  = 3'd3;
   assign mem_arburst_o = 2'b10;
   assign mem_arid_o    = ARID;
   assign mem_araddr_o  = {r_addr_q, 3'b000};

   assign w_accept = miss_req_valid_i & miss_req_ready_o;
   assign w_ar_hs  = mem_arvalid_o & mem_arready_i;
   assign w_r_done = mem_rvalid_i & mem_rready_o & mem_rlast_i;

   // Push needs no full check: full was sampled at accept and only we push.
   assign miss_addr_fifo_wren_o  = w_ar_hs;
   assign miss_addr_fifo_wdata_o = r_addr_q;

   assign mem_rready_o = (r_out_cnt != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      miss_req_ready_o = 1'b0;
      mem_arvalid_o    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            miss_req_ready_o = !miss_addr_fifo_full_i && (r_out_cnt < C_MAX_OUT);
            if (miss_req_valid_i && miss_req_ready_o) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_arvalid_o = 1'b1;
            if (mem_arready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr_q <= '0;
      end else if (w_accept) begin
         r_addr_q <= miss_req_addr_i[31:3];
      end
   end

   // r_done implies rready, so the count is never zero on a decrement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_cnt <= '0;
      end else begin
         case ({w_ar_hs, w_r_done})
            2'b10:   r_out_cnt <= r_out_cnt + C_ONE;
            2'b01:   r_out_cnt <= r_out_cnt - C_ONE;
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end

endmodule
`default_nettype wire
